hw_stack: RTL



---
 rtl/hw_stack_if.sv | 31 +++
 rtl/hw_stack.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/hw_stack_if.sv
// Stack request/response bundle between the register file / control unit and hw_stack.
`timescale 1ns/1ps
interface hw_stack_if #(
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned AMT_W = 16;

  logic              STACK_push_flag;
  logic [DATA_W-1:0] STACK_push_value;
  logic              STACK_pop_flag;
  logic              STACK_clear_req;
  logic [DATA_W-1:0] STACK_TOP;
  logic [AMT_W-1:0]  STACK_AMOUNT;
  logic              STACK_full;
  logic              STACK_empty;
  logic              STACK_busy;
  logic              STACK_overflow;
  logic              STACK_underflow;

  modport master (
    output STACK_push_flag, STACK_push_value, STACK_pop_flag, STACK_clear_req,
    input  STACK_TOP, STACK_AMOUNT, STACK_full, STACK_empty, STACK_busy,
           STACK_overflow, STACK_underflow
  );

  modport slave (
    input  STACK_push_flag, STACK_push_value, STACK_pop_flag, STACK_clear_req,
    output STACK_TOP, STACK_AMOUNT, STACK_full, STACK_empty, STACK_busy,
           STACK_overflow, STACK_underflow
  );
endinterface

// File: rtl/hw_stack.sv
// Hardware LIFO with a bulk-clear sequencer; state updates on the falling clock edge.
// Optional sticky overflow/underflow flags: define HW_STACK_ERROR_FLAGS_EN.
`timescale 1ns/1ps
module hw_stack #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input logic       clock,
  input logic       init,
  hw_stack_if.slave bus
);
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned AMT_W = 16;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   count, count_d;
  logic [DATA_W-1:0]  top, top_d;
  logic [ADDR_W-1:0]  idx, idx_d;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  below_top;
  logic               clear_done_c;
  logic [DATA_W-1:0]  mem [DEPTH];

  // Entry that becomes the new top after a plain pop (only used when count > 1).
  assign below_top    = mem[ADDR_W'(count - CNT_W'(2))];
  assign clear_done_c = (state == CLEAR) && (idx == LAST_IDX);

  always_comb begin
    state_d   = state;
    count_d   = count;
    top_d     = top;
    idx_d     = idx;
    mem_we    = 1'b0;
    mem_addr  = ADDR_W'(count);
    mem_wdata = bus.STACK_push_value;
    case (state)
      IDLE: begin
        if (bus.STACK_clear_req) begin
          state_d = CLEAR;
          count_d = '0;
          top_d   = '0;
          idx_d   = '0;
        end else if (bus.STACK_push_flag && bus.STACK_pop_flag) begin
          // Replace the top in place; on an empty stack the push simply wins.
          mem_we = 1'b1;
          top_d  = bus.STACK_push_value;
          if (count != '0) begin
            mem_addr = ADDR_W'(count - CNT_W'(1));
          end else begin
            mem_addr = '0;
            count_d  = CNT_W'(1);
          end
        end else if (bus.STACK_push_flag) begin
          if (count < DEPTH_CNT) begin
            mem_we  = 1'b1;
            count_d = count + CNT_W'(1);
            top_d   = bus.STACK_push_value;
          end
        end else if (bus.STACK_pop_flag) begin
          if (count > CNT_W'(1)) begin
            count_d = count - CNT_W'(1);
            top_d   = below_top;
          end else if (count == CNT_W'(1)) begin
            count_d = '0;
            top_d   = '0;
          end
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = idx;
        mem_wdata = '0;
        idx_d     = idx + ADDR_W'(1);
        if (clear_done_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clock or negedge init) begin
    if (!init) begin
      state <= IDLE;
      count <= '0;
      top   <= '0;
      idx   <= '0;
    end else begin
      state <= state_d;
      count <= count_d;
      top   <= top_d;
      idx   <= idx_d;
    end
  end

  // Storage is deliberately not reset; a reset mid-clear may leave it partially wiped.
  always_ff @(negedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  assign bus.STACK_TOP    = top;
  assign bus.STACK_AMOUNT = AMT_W'(count);
  assign bus.STACK_full   = (count == DEPTH_CNT);
  assign bus.STACK_empty  = (count == '0);
  assign bus.STACK_busy   = (state == CLEAR);

`ifdef HW_STACK_ERROR_FLAGS_EN
  logic ovf_q, unf_q;
  logic ovf_ev_c, unf_ev_c;

  // Dropped push at full / ignored pop at empty, plus any push/pop while clearing.
  always_comb begin
    ovf_ev_c = 1'b0;
    unf_ev_c = 1'b0;
    if (state == CLEAR) begin
      ovf_ev_c = bus.STACK_push_flag;
      unf_ev_c = bus.STACK_pop_flag;
    end else if (!bus.STACK_clear_req) begin
      ovf_ev_c = bus.STACK_push_flag && !bus.STACK_pop_flag && (count == DEPTH_CNT);
      unf_ev_c = bus.STACK_pop_flag && !bus.STACK_push_flag && (count == '0);
    end
  end

  // Completion of a clear wipes both flags, but an event on that same edge survives.
  always_ff @(negedge clock or negedge init) begin
    if (!init) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q && !clear_done_c) || ovf_ev_c;
      unf_q <= (unf_q && !clear_done_c) || unf_ev_c;
    end
  end

  assign bus.STACK_overflow  = ovf_q;
  assign bus.STACK_underflow = unf_q;
`else
  assign bus.STACK_overflow  = 1'b0;
  assign bus.STACK_underflow = 1'b0;
`endif
endmodule
